// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply/divide controller. It owns no adder: every add or
// subtract is steered through the shared execute-stage add/sub unit, one per cycle.
// Multiply is radix-2 Booth. Divide is restoring division on magnitudes.
module multdiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [WIDTH-1:0] as_operandA,
  output logic [WIDTH-1:0] as_operandB,
  output logic [4:0]       as_opcode,
  input  logic [WIDTH-1:0] as_result,
  input  logic             as_overflow
);

  localparam logic [4:0] OpAdd    = 5'b00000;
  localparam logic [4:0] OpSub    = 5'b00001;
  localparam logic [5:0] LastIter = 6'(ITERS - 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StMulIter,
    StDivAbsA,
    StDivAbsB,
    StDivIter,
    StDivFixQ,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Datapath registers are shared by both operations:
  //   acc: product high word (hi) / divide remainder (R)
  //   lo : product low word / dividend, then quotient (Q)
  //   m  : multiplicand (M) / divisor magnitude (D)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qbit_q, qbit_d;   // Booth extra bit below lo
  logic [5:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d;     // quotient must be negated
  logic             ovf_q, ovf_d;     // MinVal / -1 divide
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;

  // Scratch values for the iteration states.
  logic             sum_sign;
  logic [WIDTH-1:0] rem_shift;
  logic             rem_top;
  logic             borrow;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      qbit_q  <= 1'b0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      qbit_q  <= qbit_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  // Next-state logic and add/sub unit steering.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    m_d         = m_q;
    qbit_d      = qbit_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    exc_d       = exc_q;
    as_operandA = '0;
    as_operandB = '0;
    as_opcode   = OpAdd;
    sum_sign    = 1'b0;
    rem_shift   = '0;
    rem_top     = 1'b0;
    borrow      = 1'b0;

    case (state_q)
      StIdle: begin
        // Multiply has priority when both requests arrive together.
        if (ctrl_MULT) begin
          m_d     = data_operandA;
          acc_d   = '0;
          lo_d    = data_operandB;
          qbit_d  = 1'b0;
          cnt_d   = '0;
          state_d = StMulIter;
        end else if (ctrl_DIV) begin
          if (data_operandB == '0) begin
            res_d   = '0;
            exc_d   = 1'b1;
            state_d = StDone;
          end else begin
            lo_d    = data_operandA;
            m_d     = data_operandB;
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ovf_d   = (data_operandA == MinVal) && (&data_operandB);
            state_d = StDivAbsA;
          end
        end
      end

      StMulIter: begin
        as_operandA = acc_q;
        case ({lo_q[0], qbit_q})
          2'b01: begin
            as_operandB = m_q;
            as_opcode   = OpAdd;
          end
          2'b10: begin
            as_operandB = m_q;
            as_opcode   = OpSub;
          end
          default: begin
            as_operandB = '0;
            as_opcode   = OpAdd;
          end
        endcase
        // Recover the true sign of the 33-bit sum before the arithmetic shift.
        sum_sign = as_result[WIDTH-1] ^ as_overflow;
        acc_d    = {sum_sign, as_result[WIDTH-1:1]};
        lo_d     = {as_result[0], lo_q[WIDTH-1:1]};
        qbit_d   = lo_q[0];
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == LastIter) begin
          res_d   = lo_d;
          exc_d   = (acc_d != {WIDTH{lo_d[WIDTH-1]}});
          state_d = StDone;
        end
      end

      StDivAbsA: begin
        as_operandB = lo_q;
        as_opcode   = lo_q[WIDTH-1] ? OpSub : OpAdd;
        lo_d        = as_result;
        state_d     = StDivAbsB;
      end

      StDivAbsB: begin
        as_operandB = m_q;
        as_opcode   = m_q[WIDTH-1] ? OpSub : OpAdd;
        m_d         = as_result;
        state_d     = StDivIter;
      end

      StDivIter: begin
        // rem_top is bit 32 of the shifted remainder; if set, R' >= D regardless.
        rem_top     = acc_q[WIDTH-1];
        rem_shift   = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
        as_operandA = rem_shift;
        as_operandB = m_q;
        as_opcode   = OpSub;
        // Unsigned borrow of rem_shift - D.
        borrow = (~rem_shift[WIDTH-1] & m_q[WIDTH-1]) |
                 (~(rem_shift[WIDTH-1] ^ m_q[WIDTH-1]) & as_result[WIDTH-1]);
        if (rem_top | ~borrow) begin
          acc_d = as_result;
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift;
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LastIter) begin
          state_d = StDivFixQ;
        end
      end

      StDivFixQ: begin
        as_operandB = lo_q;
        as_opcode   = neg_q ? OpSub : OpAdd;
        // MinVal / -1 yields MinVal naturally; only the flag needs raising.
        res_d       = as_result;
        exc_d       = ovf_q;
        state_d     = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status outputs decoded from registered state.
  always_comb begin
    busy           = (state_q != StIdle);
    data_resultRDY = (state_q == StDone);
    data_result    = res_q;
    data_exception = exc_q;
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed table, randomized ops against
// an arithmetic reference model, and hand-written arbitration/reset sequences.
module tb_multdiv_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [31:0] as_operandA;
  logic [31:0] as_operandB;
  logic [4:0]  as_opcode;
  logic [31:0] as_result;
  logic        as_overflow;

  int passed = 0;
  int total  = 0;

  multdiv_sequencer #(
    .WIDTH(32),
    .ITERS(32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .as_operandA    (as_operandA),
    .as_operandB    (as_operandB),
    .as_opcode      (as_opcode),
    .as_result      (as_result),
    .as_overflow    (as_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the processor's shared add/sub unit.
  always_comb begin
    if (as_opcode == 5'd1) begin
      as_result   = as_operandA - as_operandB;
      as_overflow = (as_operandA[31] != as_operandB[31]) && (as_result[31] != as_operandA[31]);
    end else begin
      as_result   = as_operandA + as_operandB;
      as_overflow = (as_operandA[31] == as_operandB[31]) && (as_result[31] != as_operandA[31]);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Reference model: signed arithmetic on the operands, no bit-level algorithm.
  task automatic model(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc, output int lat);
    longint p;
    int     lo32;
    int     ia;
    int     ib;
    if (is_mul) begin
      p    = longint'($signed(a)) * longint'($signed(b));
      lo32 = int'(p[31:0]);
      res  = p[31:0];
      exc  = (longint'(lo32) != p);
      lat  = 33;
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
      lat = 1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      res = 32'h80000000;
      exc = 1'b1;
      lat = 36;
    end else begin
      ia  = int'(a);
      ib  = int'(b);
      res = 32'(ia / ib);
      exc = 1'b0;
      lat = 36;
    end
  endtask

  // Drive a start request; returns at the falling edge of cycle 1.
  task automatic start_op(input logic is_mul, input logic is_div,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mul;
    ctrl_DIV      = is_div;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    // Operands are sampled at start only; scramble them afterwards.
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic run_op(input logic is_mul, input logic is_div, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_exc, input string name);
    int lat;
    bit busy_ok;
    start_op(is_mul, is_div, a, b);
    lat     = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (!busy) busy_ok = 1'b0;
      if (data_resultRDY) begin
        lat = c;
        break;
      end
      @(negedge clock);
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, data_result, exp_res);
    check({name, "_exception"}, 32'(data_exception), 32'(exp_exc));
    check({name, "_busy"}, 32'(busy_ok), 32'd1);
    @(negedge clock);
    check({name, "_rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_idle_as"}, as_operandA | as_operandB | 32'(as_opcode), 32'd0);
  endtask

  typedef struct {
    logic        is_mul;
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic        exc;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] sp[5];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] eres;
    logic        eexc;
    logic        rmul;
    int          elat;
    int          pulses;
    int          first;
    int          rdy_seen;

    vecs[0] = '{1'b1, 1'b0, 32'd7,          32'hFFFFFFFA, 33, 32'hFFFFFFD6, 1'b0, "mul_7_m6"};
    vecs[1] = '{1'b1, 1'b0, 32'h00010000,   32'h00010000, 33, 32'h00000000, 1'b1, "mul_ovf"};
    vecs[2] = '{1'b0, 1'b1, 32'hFFFFFF9C,   32'd7,        36, 32'hFFFFFFF2, 1'b0, "div_m100_7"};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFFFFFF,   32'd1,        36, 32'hFFFFFFFF, 1'b0, "div_m1_1"};
    vecs[4] = '{1'b0, 1'b1, 32'd5,          32'd0,        1,  32'h00000000, 1'b1, "div_by_zero"};
    vecs[5] = '{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF, 36, 32'h80000000, 1'b1, "div_min_m1"};
    vecs[6] = '{1'b1, 1'b1, 32'd12,         32'd3,        33, 32'd36,       1'b0, "both_start"};
    vecs[7] = '{1'b0, 1'b1, 32'd100,        32'h80000000, 36, 32'd0,        1'b0, "div_by_min"};

    sp[0] = 32'd0;
    sp[1] = 32'h80000000;
    sp[2] = 32'hFFFFFFFF;
    sp[3] = 32'd1;
    sp[4] = 32'h7FFFFFFF;

    data_operandA = 32'd0;
    data_operandB = 32'd0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    reset         = 1'b0;
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_flags", {28'd0, data_exception, data_resultRDY, busy, 1'b0}, 32'd0);
    check("reset_as", as_operandA | as_operandB | 32'(as_opcode), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].is_mul, vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].lat,
             vecs[i].res, vecs[i].exc, vecs[i].name);
    end

    // Divide request mid-multiply must be ignored.
    start_op(1'b1, 1'b0, 32'd12, 32'd3);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 50; c++) begin
      ctrl_DIV      = (c == 10);
      data_operandB = 32'd0;
      if (data_resultRDY) begin
        pulses++;
        if (first == 0) first = c;
      end
      @(negedge clock);
    end
    ctrl_DIV = 1'b0;
    check("arb_pulses", 32'(pulses), 32'd1);
    check("arb_latency", 32'(first), 32'd33);
    check("arb_result", data_result, 32'd36);
    check("arb_exception", 32'(data_exception), 32'd0);

    // Reset in the middle of a divide aborts it without a ready pulse.
    start_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7);
    repeat (14) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_result", data_result, 32'd0);
    check("midrst_flags", {28'd0, data_exception, data_resultRDY, busy, 1'b0}, 32'd0);
    check("midrst_as", as_operandA | as_operandB | 32'(as_opcode), 32'd0);
    @(negedge clock);
    reset    = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("midrst_no_rdy", 32'(rdy_seen), 32'd0);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 33, 32'd12, 1'b0, "mul_after_rst");

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      rmul = 1'($urandom_range(1));
      case ($urandom_range(3))
        0: ra = 32'($urandom_range(200)) - 32'd100;
        1: ra = sp[$urandom_range(4)];
        default: ra = $urandom;
      endcase
      case ($urandom_range(3))
        0: rb = 32'($urandom_range(40)) - 32'd20;
        1: rb = sp[$urandom_range(4)];
        default: rb = $urandom >> $urandom_range(31);
      endcase
      model(rmul, ra, rb, eres, eexc, elat);
      run_op(rmul, ~rmul, ra, rb, elat, eres, eexc, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
